// File: rtl/divider_chain.sv
// Synchronous binary divider chain with a free-running periodic sampler.
// The chain runs on one clock; each stage toggles via a toggle-enable chain, never a derived clock.
module divider_chain #(
    parameter int STAGES        = 4,
    parameter int EDGE_MODE     = 0,
    parameter int SAMPLE_PERIOD = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              en,
    input  logic              din,
    input  logic              gate_in,
    output logic [STAGES-1:0] stage_q,
    output logic              wrap_q,
    output logic              gated_q,
    output logic              all_hi_n,
    output logic              sample_q,
    output logic              sample_stb
);

    localparam logic [7:0] LAST_COUNT = 8'(SAMPLE_PERIOD - 1);

    logic [STAGES-1:0] stage_r;
    logic [STAGES-1:0] tog_s;
    logic [STAGES-1:0] next_s;
    logic              wrap_r;
    logic              gated_r;
    logic              all_hi_n_r;
    logic [7:0]        cnt_r;
    logic              sample_r;
    logic              stb_r;

    // Toggle enables: stage i flips when stage i-1 flips in the selected direction.
    always_comb begin
        tog_s    = {STAGES{1'b0}};
        tog_s[0] = en;
        for (int i = 1; i < STAGES; i++) begin
            if (EDGE_MODE == 0) begin
                tog_s[i] = tog_s[i-1] & stage_r[i-1];
            end else begin
                tog_s[i] = tog_s[i-1] & ~stage_r[i-1];
            end
        end
        next_s = stage_r ^ tog_s;
    end

    // Chain state plus its derived flags, all computed from pre-edge values.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_r    <= {STAGES{1'b0}};
            wrap_r     <= 1'b0;
            gated_r    <= 1'b0;
            all_hi_n_r <= 1'b1;
        end else begin
            stage_r    <= next_s;
            wrap_r     <= en & ~(|next_s);
            gated_r    <= stage_r[STAGES-1] & gate_in;
            all_hi_n_r <= ~(&stage_r);
        end
    end

    // Periodic sampler; runs every clock regardless of en.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_r    <= 8'd0;
            sample_r <= 1'b0;
            stb_r    <= 1'b0;
        end else if (cnt_r == LAST_COUNT) begin
            cnt_r    <= 8'd0;
            sample_r <= din;
            stb_r    <= 1'b1;
        end else begin
            cnt_r    <= cnt_r + 8'd1;
            sample_r <= sample_r;
            stb_r    <= 1'b0;
        end
    end

    assign stage_q    = stage_r;
    assign wrap_q     = wrap_r;
    assign gated_q    = gated_r;
    assign all_hi_n   = all_hi_n_r;
    assign sample_q   = sample_r;
    assign sample_stb = stb_r;

endmodule

// File: tb/tb_divider_chain.sv
// Scoreboard bench for divider_chain: an up-count/period-5 instance and a down-count/period-1
// instance share stimulus; expectations are queued per edge and checked by a separate monitor.
module tb_divider_chain;

    logic       clock;
    logic       reset;
    logic       en;
    logic       din;
    logic       gate_in;
    logic [3:0] stage_a, stage_b;
    logic       wrap_a, wrap_b, gated_a, gated_b, all_hi_n_a, all_hi_n_b;
    logic       sample_a, sample_b, stb_a, stb_b;

    divider_chain #(.STAGES(4), .EDGE_MODE(0), .SAMPLE_PERIOD(5)) u_a (
        .clock(clock), .reset(reset), .en(en), .din(din), .gate_in(gate_in),
        .stage_q(stage_a), .wrap_q(wrap_a), .gated_q(gated_a), .all_hi_n(all_hi_n_a),
        .sample_q(sample_a), .sample_stb(stb_a)
    );

    divider_chain #(.STAGES(4), .EDGE_MODE(1), .SAMPLE_PERIOD(1)) u_b (
        .clock(clock), .reset(reset), .en(en), .din(din), .gate_in(gate_in),
        .stage_q(stage_b), .wrap_q(wrap_b), .gated_q(gated_b), .all_hi_n(all_hi_n_b),
        .sample_q(sample_b), .sample_stb(stb_b)
    );

    typedef struct {
        int         at;
        int         sig;
        logic [3:0] val;
    } exp_t;

    exp_t  cq[$];
    logic  sq[$];
    int    total = 0;
    int    bad = 0;
    int    edge_n = 0;
    int    k = 0;
    int    r = 0;
    int    tcount = 0;
    string nm [0:13] = '{"stage_a", "wrap_a", "gated_a", "all_hi_n_a", "sample_a", "stb_a",
                         "stage_b", "wrap_b", "gated_b", "all_hi_n_b", "sample_b", "stb_b",
                         "queue_left", "sample_left"};

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) edge_n <= edge_n + 1;

    task automatic push_exp(input int at, input int sig, input logic [3:0] val);
        exp_t e;
        e.at  = at;
        e.sig = sig;
        e.val = val;
        cq.push_back(e);
    endtask

    function automatic logic [3:0] b2n(input logic b);
        return b ? 4'd1 : 4'd0;
    endfunction

    // One non-reset clock; expected values follow k mod 16 (up) and (16-k) mod 16 (down).
    task automatic run_cycle(input logic e_in, input logic g_in);
        int   pu, pd, nu, nd, at;
        logic d;
        pu = k % 16;
        pd = (16 - pu) % 16;
        d  = ((tcount / 4) % 2) == 1;
        tcount++;
        reset   = 1'b0;
        en      = e_in;
        gate_in = g_in;
        din     = d;
        if (e_in) k++;
        r++;
        nu = k % 16;
        nd = (16 - nu) % 16;
        at = edge_n + 1;
        push_exp(at, 0, nu[3:0]);
        push_exp(at, 1, b2n(e_in && nu == 0));
        push_exp(at, 2, b2n(pu >= 8 && g_in));
        push_exp(at, 3, b2n(pu != 15));
        push_exp(at, 5, b2n(r % 5 == 0));
        if (r % 5 == 0) sq.push_back(d);
        push_exp(at, 6, nd[3:0]);
        push_exp(at, 7, b2n(e_in && nd == 0));
        push_exp(at, 8, b2n(pd >= 8 && g_in));
        push_exp(at, 9, b2n(pd != 15));
        push_exp(at, 10, b2n(d));
        push_exp(at, 11, 4'd1);
        @(posedge clock);
        #1;
    endtask

    // Reset edge with every other input asserted, to show reset wins.
    task automatic do_reset();
        int at;
        reset   = 1'b1;
        en      = 1'b1;
        din     = 1'b1;
        gate_in = 1'b1;
        k  = 0;
        r  = 0;
        at = edge_n + 1;
        push_exp(at, 0, 4'd0);
        push_exp(at, 1, 4'd0);
        push_exp(at, 2, 4'd0);
        push_exp(at, 3, 4'd1);
        push_exp(at, 4, 4'd0);
        push_exp(at, 5, 4'd0);
        push_exp(at, 6, 4'd0);
        push_exp(at, 7, 4'd0);
        push_exp(at, 9, 4'd1);
        push_exp(at, 10, 4'd0);
        push_exp(at, 11, 4'd0);
        @(posedge clock);
        #1;
    endtask

    exp_t       me;
    logic [3:0] act;
    logic       sd;

    // Monitor: drain expectations due at this edge, and check sample_q on every strobe.
    always @(negedge clock) begin
        while (cq.size() > 0 && cq[0].at <= edge_n) begin
            me = cq.pop_front();
            case (me.sig)
                0:       act = stage_a;
                1:       act = b2n(wrap_a);
                2:       act = b2n(gated_a);
                3:       act = b2n(all_hi_n_a);
                4:       act = b2n(sample_a);
                5:       act = b2n(stb_a);
                6:       act = stage_b;
                7:       act = b2n(wrap_b);
                8:       act = b2n(gated_b);
                9:       act = b2n(all_hi_n_b);
                10:      act = b2n(sample_b);
                11:      act = b2n(stb_b);
                default: act = 4'hx;
            endcase
            total++;
            if (act !== me.val) begin
                bad++;
                $display("FAIL %s edge=%0d got=%h want=%h", nm[me.sig], edge_n, act, me.val);
            end
        end
        if (stb_a === 1'b1) begin
            total++;
            if (sq.size() == 0) begin
                bad++;
                $display("FAIL sample_strobe edge=%0d got=strobe want=no strobe", edge_n);
            end else begin
                sd = sq.pop_front();
                if (sample_a !== sd) begin
                    bad++;
                    $display("FAIL sample_q_a edge=%0d got=%b want=%b", edge_n, sample_a, sd);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset   = 1'b1;
        en      = 1'b0;
        din     = 1'b0;
        gate_in = 1'b0;
        do_reset();
        do_reset();
        // Full up/down cycle including wrap; the 16th edge wraps both instances to 0.
        repeat (16) run_cycle(1'b1, 1'b1);
        // Climb to 4'hF, then gating / NAND latency with gate_in high then low.
        repeat (15) run_cycle(1'b1, 1'b1);
        run_cycle(1'b0, 1'b1);
        run_cycle(1'b0, 1'b0);
        // Reach 6 and hold with en low.
        repeat (7) run_cycle(1'b1, 1'b0);
        repeat (5) run_cycle(1'b0, 1'b1);
        // Mid-operation reset at 4'hA with the sampler counter at 3.
        while (k % 16 != 10) run_cycle(1'b1, 1'b0);
        while (r % 5 != 3) run_cycle(1'b0, 1'b0);
        do_reset();
        repeat (2) run_cycle(1'b0, 1'b0);
        repeat (6) run_cycle(1'b1, 1'b1);
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (cq.size() != 0) begin
            bad++;
            $display("FAIL %s got=%0d want=0", nm[12], cq.size());
        end
        total++;
        if (sq.size() != 0) begin
            bad++;
            $display("FAIL %s got=%0d want=0", nm[13], sq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/divider_chain.md
DIVIDER_CHAIN -- requirements
Module: divider_chain

Interface
REQ-001 SHALL have parameter STAGES, default 4: number of toggle stages in the chain, legal range 2..16.
REQ-002 SHALL have parameter EDGE_MODE, default 0: 0 = stage i toggles on falling transition of stage i-1; 1 = on rising transition.
REQ-003 SHALL have parameter SAMPLE_PERIOD, default 5: sampler interval in clocks, legal range 1..255.
REQ-004 SHALL have port clock  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port en  input  1  advance enable for the toggle chain.
REQ-007 SHALL have port din  input  1  data sampled by the periodic sampler.
REQ-008 SHALL have port gate_in  input  1  gating term ANDed with the chain MSB.
REQ-009 SHALL have port stage_q  output  STAGES  registered toggle-stage values, bit 0 fastest.
REQ-010 SHALL have port wrap_q  output  1  registered one-cycle pulse on chain return to zero.
REQ-011 SHALL have port gated_q  output  1  registered stage MSB AND gate_in.
REQ-012 SHALL have port all_hi_n  output  1  registered NAND of all stages.
REQ-013 SHALL have port sample_q  output  1  registered periodic sample of din.
REQ-014 SHALL have port sample_stb  output  1  one-cycle pulse in the cycle sample_q is updated.

Function
REQ-015 SHALL toggle stage_q[0] on every clock edge with en=1 and hold all stages when en=0.
REQ-016 SHALL toggle stage_q[i], i>=1, at the same edge where stage_q[i-1] makes the EDGE_MODE-selected transition; the chain is fully synchronous, with no ripple and no derived clocks.
REQ-017 SHALL, with EDGE_MODE=0, make stage_q equal k mod 2^STAGES after k enabled cycles from reset (up count).
REQ-018 SHALL, with EDGE_MODE=1, make stage_q equal (2^STAGES - k) mod 2^STAGES after k enabled cycles from reset (down count).
REQ-019 SHALL wrap naturally at the count boundary, with no saturation: all-ones to zero in mode 0, zero to all-ones in mode 1.
REQ-020 SHALL assert wrap_q for exactly the one cycle following an enabled edge whose next stage_q is all zeros; wrap_q SHALL be 0 otherwise, including while held at zero with en=0.
REQ-021 SHALL register gated_q <= stage_q[STAGES-1] & gate_in from pre-edge values, giving one clock of latency.
REQ-022 SHALL register all_hi_n <= ~(&stage_q) from pre-edge values, giving one clock of latency.
REQ-023 SHALL run the sampler counter 0..SAMPLE_PERIOD-1 freely every clock out of reset, independent of en.
REQ-024 SHALL, at the edge where the counter equals SAMPLE_PERIOD-1, load sample_q <= din, pulse sample_stb for the following cycle, and reset the counter to 0.
REQ-025 SHALL, with SAMPLE_PERIOD=1, load din every clock and hold sample_stb constantly 1.
REQ-026 SHALL hold sample_q and keep sample_stb at 0 between samples.

Reset
REQ-027 SHALL, when reset=1 at a clock edge, set stage_q=0, wrap_q=0, gated_q=0, all_hi_n=1, sample_q=0, sample_stb=0, and the sampler counter=0.
REQ-028 SHALL give reset priority over en, din and gate_in; a mid-count reset SHALL restart counting and sampling from their initial state.
REQ-029 SHALL begin counting on the first edge with reset=0, which is sampler count 0.

Verification
REQ-030 SHALL cover mode 0 up count: STAGES=4, reset, en=1 for 16 cycles -> stage_q steps 1..15 then 0, and wrap_q is high only in the cycle after the 16th edge.
REQ-031 SHALL cover mode 1 down count: EDGE_MODE=1, en=1 for 3 cycles -> stage_q sequence 4'hF, 4'hE, 4'hD.
REQ-032 SHALL cover enable hold: en=0 for 5 cycles at stage_q=4'h6 -> stage_q holds at 6 and wrap_q stays 0.
REQ-033 SHALL cover the sampler: SAMPLE_PERIOD=5, din toggling every 4 cycles -> sample_stb high 1 cycle in 5, first pulse after the 5th edge post-reset, and sample_q equals din at the 5th edge.
REQ-034 SHALL cover gating and NAND latency: stage_q=4'hF with gate_in=1 -> gated_q=1 and all_hi_n=0 one cycle later; gate_in=0 -> gated_q=0 on the next cycle.
REQ-035 SHALL cover mid-operation reset: reset at stage_q=4'hA with the counter at 3 -> next cycle all outputs match REQ-027, and the next sample_stb arrives 5 cycles after reset deasserts.
